// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file debug port: FSM states, register
// indices, op-bus field positions and the op builder.
// Latency: n/a (declarations only). Backpressure: n/a.
package regfile_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_STALL  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_RESP   = 3'd3,
      ST_VERIFY = 3'd4
   } state_t;

   // Register-file slot indices; only X..S are writable.
   localparam logic [3:0] IDX_X      = 4'd0;
   localparam logic [3:0] IDX_Y      = 4'd1;
   localparam logic [3:0] IDX_A      = 4'd2;
   localparam logic [3:0] IDX_S      = 4'd3;
   localparam logic [3:0] IDX_ZERO   = 4'd4;
   localparam logic [3:0] IDX_ONE    = 4'd5;
   localparam logic [3:0] IDX_MINUS1 = 4'd6;
   localparam logic [3:0] IDX_Z      = 4'd7;
   localparam logic [3:0] IDX_NMI    = 4'd8;
   localparam logic [3:0] IDX_RST    = 4'd9;
   localparam logic [3:0] IDX_BRK    = 4'd10;

   // Op bus layout: [6]=we, [5:4]=write index, [3:0]=read index.
   localparam int WE_BIT = 6;
   localparam int WR_LSB = 4;
   localparam int RD_LSB = 0;

   // Reads always address the slot on the read field; writes also place the
   // low two index bits on the write field so the slot reads back its new value.
   function automatic logic [6:0] mk_op(input logic we, input logic [3:0] idx);
      logic [6:0] op;
      op = '0;
      op[WE_BIT] = we;
      op[WR_LSB +: 2] = we ? idx[1:0] : 2'b00;
      op[RD_LSB +: 4] = idx;
      return op;
   endfunction

endpackage

// File: rtl/regfile_dbg_port.sv
// Debug initiator that stalls the CPU and performs one register-file read/write per request.
// Latency: accept -> stall (>=1 cycle until cpu_sync) -> access -> resp (+1 verify cycle on writes with REGFILE_DBG_VERIFY_EN).
// Backpressure: response held until resp_ready; a request offered during that handshake while stalled is taken back-to-back.
module regfile_dbg_port
   import regfile_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [3:0] req_idx,
   input  logic [7:0] req_wdata,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic [7:0] resp_data,
   output logic       resp_err,
   input  logic       cpu_sync,
   output logic       cpu_stall,
   output logic       rf_own,
   output logic [6:0] rf_op,
   output logic [7:0] rf_di,
   input  logic [7:0] rf_do
);

   // Last stall cycle index: STALL lasts at most TIMEOUT cycles.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic            live_q;
   logic            we_q;
   logic [3:0]      idx_q;
   logic [7:0]      wdata_q;
   logic [TO_W-1:0] cnt_q;
   logic [7:0]      resp_data_q;
   logic            resp_err_q;
   logic            stall_q;

   logic req_ill;
   logic burst;
   logic accept;
   logic timeout;

   assign req_ill = req_we && (req_idx[3:2] != 2'b00);
   assign burst   = (state_q == ST_RESP) && resp_ready && req_valid && stall_q;
   assign accept  = ((state_q == ST_IDLE) && live_q && req_valid) || burst;
   assign timeout = (state_q == ST_STALL) && !cpu_sync && (cnt_q == TO_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = req_ill ? ST_RESP : ST_STALL;
         ST_STALL:  begin
            if (cpu_sync)     state_d = ST_ACCESS;
            else if (timeout) state_d = ST_RESP;
         end
`ifdef REGFILE_DBG_VERIFY_EN
         ST_ACCESS: state_d = we_q ? ST_VERIFY : ST_RESP;
         ST_VERIFY: state_d = ST_RESP;
`else
         ST_ACCESS: state_d = ST_RESP;
`endif
         ST_RESP:   begin
            if (resp_ready) begin
               if (burst) state_d = req_ill ? ST_RESP : ST_ACCESS;
               else       state_d = ST_IDLE;
            end
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output decode; the register file is only driven while we own it.
   always_comb begin
      req_ready  = ((state_q == ST_IDLE) && live_q) || burst;
      resp_valid = (state_q == ST_RESP);
      resp_data  = resp_data_q;
      resp_err   = resp_err_q;
      cpu_stall  = stall_q;
      rf_own     = 1'b0;
      rf_op      = '0;
      rf_di      = '0;
      if (state_q == ST_ACCESS) begin
         rf_own = 1'b1;
         rf_op  = mk_op(we_q, idx_q);
         rf_di  = we_q ? wdata_q : 8'h00;
      end
`ifdef REGFILE_DBG_VERIFY_EN
      if (state_q == ST_VERIFY) begin
         rf_own = 1'b1;
         rf_op  = mk_op(1'b0, idx_q);
      end
`endif
   end

   // Request capture, stall hold, timeout counter and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q      <= 1'b0;
         we_q        <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
         stall_q     <= 1'b0;
      end else begin
         live_q <= 1'b1;
         if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            if (req_ill) begin
               resp_data_q <= 8'h00;
               resp_err_q  <= 1'b1;
            end
         end
         case (state_q)
            ST_IDLE: begin
               if (accept && !req_ill) begin
                  stall_q <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            ST_STALL: begin
               cnt_q <= cnt_q + 1'b1;
               if (timeout) begin
                  stall_q     <= 1'b0;
                  resp_data_q <= 8'h00;
                  resp_err_q  <= 1'b1;
               end
            end
            ST_ACCESS: begin
               resp_data_q <= we_q ? wdata_q : rf_do;
               resp_err_q  <= 1'b0;
            end
`ifdef REGFILE_DBG_VERIFY_EN
            ST_VERIFY: begin
               if (rf_do != wdata_q) begin
                  resp_data_q <= rf_do;
                  resp_err_q  <= 1'b1;
               end
            end
`endif
            ST_RESP: begin
               if (resp_ready && !burst) stall_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Directed bench for regfile_dbg_port with a behavioural register file.
// Inputs driven and outputs checked 1 time unit after each rising edge.
// Covers reset, read, write, illegal write, timeout, burst with backpressure, reset mid-access.
module tb_regfile_dbg_port;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_we, resp_ready, cpu_sync;
   logic [3:0] req_idx;
   logic [7:0] req_wdata;
   logic       req_ready, resp_valid, resp_err, cpu_stall, rf_own;
   logic [7:0] resp_data, rf_di, rf_do;
   logic [6:0] rf_op;

   int n_chk  = 0;
   int n_fail = 0;
   int stall_tot = 0;
   int own_tot   = 0;
   int bad_tot   = 0;

   logic [7:0] mrf [16];

   always #5 clk = ~clk;

   regfile_dbg_port #(.TIMEOUT(4), .TO_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_idx(req_idx), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err),
      .cpu_sync(cpu_sync), .cpu_stall(cpu_stall),
      .rf_own(rf_own), .rf_op(rf_op), .rf_di(rf_di), .rf_do(rf_do)
   );

   // Register-file model: combinational read, write commits on the clock edge.
   assign rf_do = mrf[rf_op[3:0]];
   always @(posedge clk) begin
      if (rf_op[6]) begin
`ifdef REGFILE_DBG_VERIFY_EN
         if (rf_op[5:4] != 2'd1) mrf[{2'b00, rf_op[5:4]}] <= rf_di;
`else
         mrf[{2'b00, rf_op[5:4]}] <= rf_di;
`endif
      end
   end

   // Cycle monitor: stall/own occupancy and ownership rule violations.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cpu_stall) stall_tot++;
         if (rf_own) own_tot++;
         if (!rf_own && rf_op != 7'h00) bad_tot++;
         if (rf_own && !cpu_stall) bad_tot++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [3:0] idx, input logic [7:0] wd);
      req_valid = 1'b1;
      req_we    = we;
      req_idx   = idx;
      req_wdata = wd;
   endtask

   initial begin
      int s0, o0, waited;
      for (int i = 0; i < 16; i++) mrf[i] = 8'h00;
      mrf[0] = 8'h11; mrf[1] = 8'h22; mrf[2] = 8'h41; mrf[3] = 8'h33;
      mrf[5] = 8'h01; mrf[6] = 8'hFF;
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_idx = 4'd0; req_wdata = 8'h00;
      resp_ready = 1'b0; cpu_sync = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp", {resp_err, resp_data}, 9'h000);
      check("rst_stall_own", {cpu_stall, rf_own}, 2'b00);
      check("rst_rf_op_di", {rf_op, rf_di}, 15'h0000);
      rst_n = 1'b1;
      tick(); tick();
      check("idle_req_ready", req_ready, 1'b1);

      // Read A, cpu_sync raised after three stall cycles
      issue(1'b0, 4'd2, 8'h00);
      tick();
      req_valid = 1'b0;
      check("rdA_stall", cpu_stall, 1'b1);
      check("rdA_no_own", rf_own, 1'b0);
      tick(); tick(); tick();
      cpu_sync = 1'b1;
      tick();
      cpu_sync = 1'b0;
      check("rdA_own", rf_own, 1'b1);
      check("rdA_op", rf_op, 7'h02);
      tick();
      check("rdA_valid", resp_valid, 1'b1);
      check("rdA_data", resp_data, 8'h41);
      check("rdA_err", resp_err, 1'b0);
      check("rdA_stall_in_resp", cpu_stall, 1'b1);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("rdA_released", {resp_valid, cpu_stall}, 2'b00);

      // Write S = FD, CPU already synced
      cpu_sync = 1'b1;
      issue(1'b1, 4'd3, 8'hFD);
      tick();
      req_valid = 1'b0;
      tick();
      check("wrS_op", rf_op, 7'h73);
      check("wrS_di", rf_di, 8'hFD);
      tick();
`ifdef REGFILE_DBG_VERIFY_EN
      check("wrS_verify_op", rf_op, 7'h03);
      tick();
`endif
      cpu_sync = 1'b0;
      check("wrS_valid", resp_valid, 1'b1);
      check("wrS_data", resp_data, 8'hFD);
      check("wrS_err", resp_err, 1'b0);
      check("wrS_model", mrf[3], 8'hFD);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;

      // Illegal write to idx 6: immediate error, no stall or access
      s0 = stall_tot; o0 = own_tot;
      issue(1'b1, 4'd6, 8'h99);
      tick();
      req_valid = 1'b0;
      check("ill_valid", resp_valid, 1'b1);
      check("ill_err_data", {resp_err, resp_data}, 9'h100);
      check("ill_stall", cpu_stall, 1'b0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("ill_no_stall_cycles", stall_tot - s0, 0);
      check("ill_no_own_cycles", own_tot - o0, 0);
      check("ill_model", mrf[6], 8'hFF);

      // Timeout: no sync for TIMEOUT=4 stall cycles
      s0 = stall_tot; o0 = own_tot;
      issue(1'b0, 4'd0, 8'h00);
      tick();
      req_valid = 1'b0;
      waited = 0;
      for (int i = 0; i < 20 && !resp_valid; i++) begin
         tick();
         waited++;
      end
      check("to_resp_seen", resp_valid, 1'b1);
      check("to_wait", waited, 4);
      check("to_err", resp_err, 1'b1);
      check("to_stall_low", cpu_stall, 1'b0);
      check("to_stall_cycles", stall_tot - s0, 4);
      check("to_no_own", own_tot - o0, 0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;

      // Burst: read X, then write Y=55 behind 3 cycles of backpressure
      cpu_sync = 1'b1;
      issue(1'b0, 4'd0, 8'h00);
      tick();
      req_valid = 1'b0;
      tick();
      cpu_sync = 1'b0;
      tick();
      check("bu_rdX_data", resp_data, 8'h11);
      issue(1'b1, 4'd1, 8'h55);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bu_hold_valid", resp_valid, 1'b1);
         check("bu_hold_data", resp_data, 8'h11);
         check("bu_hold_ready", req_ready, 1'b0);
      end
      resp_ready = 1'b1;
      #1;
      check("bu_accept_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      resp_ready = 1'b0;
      check("bu_access_stall", cpu_stall, 1'b1);
      check("bu_access_op", rf_op, 7'h51);
      check("bu_access_di", rf_di, 8'h55);
      tick();
`ifdef REGFILE_DBG_VERIFY_EN
      tick();
      check("bu_wr_data", resp_data, 8'h22);
      check("bu_wr_err", resp_err, 1'b1);
      check("bu_model_y", mrf[1], 8'h22);
`else
      check("bu_wr_data", resp_data, 8'h55);
      check("bu_wr_err", resp_err, 1'b0);
      check("bu_model_y", mrf[1], 8'h55);
`endif
      check("bu_wr_valid", resp_valid, 1'b1);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("bu_released", cpu_stall, 1'b0);

`ifdef REGFILE_DBG_VERIFY_EN
      // Verify failure: model ignores writes to Y
      cpu_sync = 1'b1;
      issue(1'b1, 4'd1, 8'hAA);
      tick();
      req_valid = 1'b0;
      tick(); tick(); tick();
      cpu_sync = 1'b0;
      check("vf_valid", resp_valid, 1'b1);
      check("vf_err", resp_err, 1'b1);
      check("vf_data", resp_data, 8'h22);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
`endif

      // Reset while owning the register file
      cpu_sync = 1'b1;
      issue(1'b0, 4'd2, 8'h00);
      tick();
      req_valid = 1'b0;
      tick();
      cpu_sync = 1'b0;
      check("mr_own_before", rf_own, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mr_stall", cpu_stall, 1'b0);
      check("mr_own", {rf_own, rf_op}, 8'h00);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      check("mr_idle", {req_ready, resp_valid}, 2'b10);

      check("own_rules", bad_tot, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
